// File: rtl/data_mux_nport.sv
// N-port GPU RAM command mux: per-port show-ahead FIFOs, round-robin or fixed-priority
// arbitration onto one RAM port, and a one-hot delay line that signals read completion.
module data_mux_nport #(
  parameter int PORTS             = 4,
  parameter int ADDR_W            = 20,
  parameter int FIFO_DEPTH        = 4,
  parameter int READ_CLOCK_CYCLES = 2,
  parameter int REGISTER_GPU_PORT = 1,
  parameter int ARB_MODE          = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [15:0]             gpu_data_in,
  input  logic [PORTS-1:0]        wr_ena,
  input  logic [PORTS-1:0]        rd_req,
  input  logic [PORTS-1:0]        ena_16bit,
  input  logic [PORTS*ADDR_W-1:0] address,
  input  logic [PORTS*16-1:0]     data_in,
  output logic                    gpu_wr_ena,
  output logic                    gpu_ena_16bit,
  output logic [ADDR_W-1:0]       gpu_address,
  output logic [15:0]             gpu_data_out,
  output logic [PORTS-1:0]        gpu_rd_rdy,
  output logic [15:0]             data_out,
  output logic [PORTS-1:0]        fifo_full,
  output logic [PORTS-1:0]        overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int GW = $clog2(PORTS);
  localparam int DL = READ_CLOCK_CYCLES + REGISTER_GPU_PORT;

  typedef struct packed {
    logic              rd;
    logic              wr;
    logic              e16;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
  } entry_t;

  entry_t           mem_q [PORTS][FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_q [PORTS];
  logic [PW-1:0]    wr_ptr_d [PORTS];
  logic [PW-1:0]    rd_ptr_q [PORTS];
  logic [PW-1:0]    rd_ptr_d [PORTS];
  logic [CW-1:0]    cnt_q [PORTS];
  logic [CW-1:0]    cnt_d [PORTS];
  logic [PORTS-1:0] ovf_q, ovf_d;
  logic [PORTS-1:0] empty, full, req, enq, deq;
  entry_t           new_e [PORTS];
  entry_t           cmd, cmd_d, cmd_q, gpu_cmd;
  logic [GW-1:0]    last_q, last_d, gnt_idx;
  logic             gnt_vld;
  logic [PORTS-1:0] dly_q [DL];
  logic [PORTS-1:0] dly_d [DL];
  int unsigned      cand;

  always_comb begin
    for (int unsigned p = 0; p < PORTS; p++) begin
      empty[p]     = (cnt_q[p] == '0);
      full[p]      = (cnt_q[p] == CW'(FIFO_DEPTH));
      req[p]       = rd_req[p] | wr_ena[p];
      // A simultaneous write and read is stored as a write only.
      new_e[p].rd   = rd_req[p] & ~wr_ena[p];
      new_e[p].wr   = wr_ena[p];
      new_e[p].e16  = ena_16bit[p];
      new_e[p].addr = address[p*ADDR_W +: ADDR_W];
      new_e[p].data = data_in[p*16 +: 16];
    end
  end

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    if (ARB_MODE == 1) begin
      for (int unsigned i = 0; i < PORTS; i++) begin
        cand = PORTS - 1 - i;
        if (!empty[cand]) begin
          gnt_vld = 1'b1;
          gnt_idx = GW'(cand);
        end
      end
    end else begin
      for (int unsigned off = 1; off <= PORTS; off++) begin
        cand = 32'(last_q) + off;
        if (cand >= PORTS) cand = cand - PORTS;
        if (!gnt_vld && !empty[cand]) begin
          gnt_vld = 1'b1;
          gnt_idx = GW'(cand);
        end
      end
    end
    cmd = gnt_vld ? mem_q[gnt_idx][rd_ptr_q[gnt_idx]] : '0;
  end

  always_comb begin
    for (int unsigned p = 0; p < PORTS; p++) begin
      deq[p]      = gnt_vld && (gnt_idx == GW'(p));
      // A pop in the same cycle frees the slot, so a full FIFO still accepts.
      enq[p]      = req[p] && (!full[p] || deq[p]);
      ovf_d[p]    = ovf_q[p] | (req[p] & full[p] & ~deq[p]);
      wr_ptr_d[p] = wr_ptr_q[p] + PW'(enq[p]);
      rd_ptr_d[p] = rd_ptr_q[p] + PW'(deq[p]);
      cnt_d[p]    = cnt_q[p] + CW'(enq[p]) - CW'(deq[p]);
    end
    last_d   = gnt_vld ? gnt_idx : last_q;
    cmd_d    = cmd;
    dly_d[0] = (gnt_vld && cmd.rd) ? (PORTS'(1) << gnt_idx) : '0;
    for (int unsigned i = 1; i < DL; i++) dly_d[i] = dly_q[i-1];
  end

  always_ff @(posedge clk) begin
    for (int unsigned p = 0; p < PORTS; p++)
      if (enq[p]) mem_q[p][wr_ptr_q[p]] <= new_e[p];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned p = 0; p < PORTS; p++) begin
        wr_ptr_q[p] <= '0;
        rd_ptr_q[p] <= '0;
        cnt_q[p]    <= '0;
      end
      ovf_q  <= '0;
      last_q <= GW'(PORTS - 1);
      cmd_q  <= '0;
      for (int unsigned i = 0; i < DL; i++) dly_q[i] <= '0;
    end else begin
      for (int unsigned p = 0; p < PORTS; p++) begin
        wr_ptr_q[p] <= wr_ptr_d[p];
        rd_ptr_q[p] <= rd_ptr_d[p];
        cnt_q[p]    <= cnt_d[p];
      end
      ovf_q  <= ovf_d;
      last_q <= last_d;
      cmd_q  <= cmd_d;
      for (int unsigned i = 0; i < DL; i++) dly_q[i] <= dly_d[i];
    end
  end

  assign gpu_cmd       = (REGISTER_GPU_PORT != 0) ? cmd_q : cmd;
  assign gpu_wr_ena    = gpu_cmd.wr;
  assign gpu_ena_16bit = gpu_cmd.e16;
  assign gpu_address   = gpu_cmd.addr;
  assign gpu_data_out  = gpu_cmd.data;
  assign gpu_rd_rdy    = dly_q[DL-1];
  assign data_out      = gpu_data_in;
  assign fifo_full     = full;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_data_mux_nport.sv
// Directed bench for data_mux_nport: default, combinational-GPU-port and fixed-priority
// instances share the host inputs; a small RAM model returns addr[15:0]^0xA5A5.
module tb_data_mux_nport;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] gpu_data_in;
  logic [3:0]  wr_ena = '0, rd_req = '0, ena_16bit = '0;
  logic [79:0] address = '0;
  logic [63:0] data_in = '0;

  logic        a_wr, a_e16, n_wr, n_e16, f_wr, f_e16;
  logic [19:0] a_addr, n_addr, f_addr;
  logic [15:0] a_dout, n_dout, f_dout, a_data, n_data, f_data;
  logic [3:0]  a_rdy, n_rdy, f_rdy, a_full, n_full, f_full, a_ovf, n_ovf, f_ovf;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_cnt, rdy_cnt;

  always #5 clk = ~clk;

  data_mux_nport dut_a (
    .clk(clk), .reset(reset), .gpu_data_in(gpu_data_in), .wr_ena(wr_ena), .rd_req(rd_req),
    .ena_16bit(ena_16bit), .address(address), .data_in(data_in), .gpu_wr_ena(a_wr),
    .gpu_ena_16bit(a_e16), .gpu_address(a_addr), .gpu_data_out(a_dout), .gpu_rd_rdy(a_rdy),
    .data_out(a_data), .fifo_full(a_full), .overflow(a_ovf));

  data_mux_nport #(.REGISTER_GPU_PORT(0)) dut_n (
    .clk(clk), .reset(reset), .gpu_data_in(gpu_data_in), .wr_ena(wr_ena), .rd_req(rd_req),
    .ena_16bit(ena_16bit), .address(address), .data_in(data_in), .gpu_wr_ena(n_wr),
    .gpu_ena_16bit(n_e16), .gpu_address(n_addr), .gpu_data_out(n_dout), .gpu_rd_rdy(n_rdy),
    .data_out(n_data), .fifo_full(n_full), .overflow(n_ovf));

  data_mux_nport #(.ARB_MODE(1)) dut_f (
    .clk(clk), .reset(reset), .gpu_data_in(gpu_data_in), .wr_ena(wr_ena), .rd_req(rd_req),
    .ena_16bit(ena_16bit), .address(address), .data_in(data_in), .gpu_wr_ena(f_wr),
    .gpu_ena_16bit(f_e16), .gpu_address(f_addr), .gpu_data_out(f_dout), .gpu_rd_rdy(f_rdy),
    .data_out(f_data), .fifo_full(f_full), .overflow(f_ovf));

  // RAM model with READ_CLOCK_CYCLES=2 latency, following the default instance's GPU port.
  logic [15:0] ram_pipe0, ram_pipe1;
  always @(posedge clk) begin
    ram_pipe0 <= a_addr[15:0] ^ 16'hA5A5;
    ram_pipe1 <= ram_pipe0;
  end
  assign gpu_data_in = ram_pipe1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int p, input logic [19:0] a);
    address[p*20 +: 20] = a;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    #2 reset = 1'b0;
    step();
    check("rst_addr", 32'(a_addr), 0);
    check("rst_rdy", 32'(a_rdy), 0);
    check("rst_full", 32'(a_full), 0);
    check("rst_ovf", 32'(f_ovf), 0);
    step();
    reset = 1'b1;

    // Single read on port 1
    set_addr(1, 20'h12345);
    rd_req = 4'b0010;
    step();
    rd_req = '0;
    check("nr_cmd_addr", 32'(n_addr), 32'h12345);
    check("nr_cmd_wr", 32'(n_wr), 0);
    step();
    check("rd_cmd_addr", 32'(a_addr), 32'h12345);
    check("rd_cmd_wr", 32'(a_wr), 0);
    check("rd_rdy_c2", 32'(a_rdy), 0);
    step();
    check("nr_rdy_c3", 32'(n_rdy), 4'b0010);
    check("rd_rdy_c3", 32'(a_rdy), 0);
    step();
    check("rd_rdy_c4", 32'(a_rdy), 4'b0010);
    check("rd_data", 32'(a_data), 16'h86E0);
    check("nr_rdy_c4", 32'(n_rdy), 0);

    // Round-robin: all four ports read at once
    do_reset();
    for (int p = 0; p < 4; p++) set_addr(p, 20'h0A000 | 20'(p));
    rd_req = 4'hF;
    step();
    rd_req = '0;
    for (int c = 1; c <= 7; c++) begin
      check("rr_addr", 32'(a_addr), (c >= 2 && c <= 5) ? (32'h0A000 | 32'(c - 2)) : 0);
      check("rr_rdy", 32'(a_rdy), (c >= 4) ? (32'd1 << (c - 4)) : 0);
      if (c >= 4) check("rr_data", 32'(a_data), 32'h05A5 ^ 32'(c - 4));
      step();
    end

    // Fixed priority: port 0 streams 10 reads, port 3 reads once
    do_reset();
    set_addr(0, 20'h00100);
    set_addr(3, 20'h33333);
    rd_req = 4'b1001;
    step();
    for (int c = 1; c <= 14; c++) begin
      check("fp_addr", 32'(f_addr), (c >= 2 && c <= 11) ? 32'h00100 : (c == 12) ? 32'h33333 : 0);
      check("fp_rdy", 32'(f_rdy), (c == 14) ? 4'b1000 : (c >= 4 && c <= 13) ? 4'b0001 : 0);
      rd_req = (c <= 9) ? 4'b0001 : 4'b0000;
      step();
    end

    // Overflow on port 2 while port 0 holds the fixed-priority bus
    do_reset();
    set_addr(0, 20'h00200);
    set_addr(2, 20'h22000);
    wr_cnt = 0;
    for (int c = 0; c <= 20; c++) begin
      if (c == 3) check("ov_full_c3", 32'(f_full[2]), 0);
      if (c == 4) begin
        check("ov_full_c4", 32'(f_full[2]), 1);
        check("ov_ovf_c4", 32'(f_ovf[2]), 0);
      end
      if (c == 5) check("ov_ovf_c5", 32'(f_ovf[2]), 1);
      if (f_wr) begin
        check("ov_wdata", 32'(f_dout), 32'(wr_cnt));
        check("ov_waddr", 32'(f_addr), 32'h22000);
        wr_cnt++;
      end
      rd_req       = (c <= 7) ? 4'b0001 : 4'b0000;
      wr_ena       = (c <= 5) ? 4'b0100 : 4'b0000;
      data_in[47:32] = 16'(c);
      step();
    end
    check("ov_wcount", 32'(wr_cnt), 4);
    check("ov_sticky", 32'(f_ovf), 4'b0100);
    check("ov_full_end", 32'(f_full), 0);

    // Reset mid-operation, one cycle after a read grant
    set_addr(1, 20'h12345);
    rd_req = 4'b0010;
    step();
    rd_req = '0;
    step();
    check("rm_pre_addr", 32'(a_addr), 32'h12345);
    reset = 1'b0;
    #1;
    check("rm_addr", 32'(a_addr), 0);
    check("rm_rdy", 32'(a_rdy), 0);
    check("rm_ovf", 32'(f_ovf), 0);
    check("rm_full", 32'(a_full), 0);
    rdy_cnt = 0;
    for (int k = 0; k < 2; k++) begin
      step();
      rdy_cnt += int'(a_rdy != 0) + int'(n_rdy != 0);
    end
    reset = 1'b1;
    set_addr(1, 20'h00042);
    rd_req = 4'b0010;
    step();
    rd_req = '0;
    rdy_cnt += int'(a_rdy != 0);
    step();
    check("rm_new_addr", 32'(a_addr), 32'h00042);
    rdy_cnt += int'(a_rdy != 0);
    step();
    rdy_cnt += int'(a_rdy != 0);
    check("rm_no_stale", 32'(rdy_cnt), 0);
    step();
    check("rm_new_rdy", 32'(a_rdy), 4'b0010);
    check("rm_new_data", 32'(a_data), 16'hA5E7);

    // Write + read collision on port 0
    do_reset();
    set_addr(0, 20'h00ABC);
    data_in[15:0] = 16'hBEEF;
    ena_16bit = 4'b0001;
    wr_ena = 4'b0001;
    rd_req = 4'b0001;
    step();
    wr_ena = '0;
    rd_req = '0;
    ena_16bit = '0;
    wr_cnt = 0;
    rdy_cnt = 0;
    for (int c = 1; c <= 8; c++) begin
      if (c == 2) begin
        check("col_wr", 32'(a_wr), 1);
        check("col_e16", 32'(a_e16), 1);
        check("col_data", 32'(a_dout), 32'hBEEF);
        check("col_addr", 32'(a_addr), 32'h00ABC);
      end
      wr_cnt  += int'(a_wr);
      rdy_cnt += int'(a_rdy != 0);
      step();
    end
    check("col_wcount", 32'(wr_cnt), 1);
    check("col_no_rdy", 32'(rdy_cnt), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mux_nport.md
# data_mux_nport

Parametrised N-port successor to the 2-port GPU RAM data mux. It accepts read and write commands from up to PORTS host interfaces (Z80, RS232, DMA, and so on). Each port's commands are buffered in a per-port FIFO of configurable depth, then arbitrated onto the single GPU RAM port by round-robin or fixed priority. Read completion is signalled per port after a fixed RAM latency. Adds 16-bit transfers, overflow reporting, and arbitration mode selection.

## Interface
- PORTS, 4: number of host ports, 2..8.
- ADDR_W, 20: address width.
- FIFO_DEPTH, 4: commands buffered per port; power of two, 2..16.
- READ_CLOCK_CYCLES, 2: cycles from a command on the GPU port to valid gpu_data_in.
- REGISTER_GPU_PORT, 1: 1 registers all GPU outputs, adding +1 cycle; 0 drives them combinationally from the grant.
- ARB_MODE, 0: 0 = round-robin; 1 = fixed priority, port 0 highest.
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset (low = in reset).
- gpu_data_in  input  16  RAM read data, valid when the matching gpu_rd_rdy pulses.
- wr_ena  input  PORTS  per-port write strobe, 1-cycle pulse.
- rd_req  input  PORTS  per-port read strobe, 1-cycle pulse.
- ena_16bit  input  PORTS  per-port 16-bit transfer flag, sampled with the strobe.
- address  input  PORTS*ADDR_W  port p at [p*ADDR_W +: ADDR_W].
- data_in  input  PORTS*16  port p at [p*16 +: 16]; only [7:0] is used when ena_16bit=0.
- gpu_wr_ena  output  1  1-cycle write pulse to RAM.
- gpu_ena_16bit  output  1  width of the current command.
- gpu_address  output  ADDR_W  current command address.
- gpu_data_out  output  16  current write data.
- gpu_rd_rdy  output  PORTS  1-cycle pulse; gpu_data_in is valid for port p.
- data_out  output  16  gpu_data_in passed through; the receiver latches on its gpu_rd_rdy.
- fifo_full  output  PORTS  port FIFO holds FIFO_DEPTH entries.
- overflow  output  PORTS  sticky; a command arrived while the FIFO was full.

## Operation
- **Enqueue.** A port enqueues when (rd_req[p] | wr_ena[p]) is sampled high.
  - The entry is {rd, wr, ena_16bit, address, data}.
  - If rd and wr are both high, wr wins and rd is cleared in the entry.
- **Full FIFO.** When fifo_full[p]=1, a new command is dropped and overflow[p] is set. overflow clears only on reset. If a dequeue and an enqueue happen in the same cycle on a full FIFO, the enqueue is accepted.
- **FIFOs.** Each FIFO is show-ahead with wrapping read/write pointers and a count. Empty and full are derived from the count.
- **Arbitration.** At most one grant per cycle, among ports with non-empty FIFOs.
  - Round-robin: search starts at last_grant+1 mod PORTS. last_grant updates only on a grant.
  - Fixed priority: the lowest-numbered non-empty port wins. Lower-priority ports may starve, by design.
- **Grant.** A grant pops the head entry and drives it onto the GPU port. gpu_wr_ena = entry.wr.
- **Idle.** With no grant, all gpu_* outputs are 0.
- **Read tracking.** A granted read enters a one-hot (PORTS-bit) delay line of length READ_CLOCK_CYCLES+REGISTER_GPU_PORT. Its output is gpu_rd_rdy.
- **Concurrency.** Reads and writes interleave freely. Throughput is one command per cycle.
- **Reset (reset=0), asynchronous.** Values:
  - all FIFOs empty;
  - last_grant = PORTS-1, so port 0 is first;
  - delay line cleared;
  - all outputs 0.
- **Reset mid-operation.** Queued commands are discarded and in-flight reads produce no gpu_rd_rdy pulse. Commands sampled on the first clock edge after reset release are accepted.

## Timing
- A strobe in cycle 0 is written at edge 1. The entry is grantable in cycle 1, including when the FIFO was empty (no bypass).
- REGISTER_GPU_PORT=1: the GPU command is valid in cycle 2, and gpu_rd_rdy[p] pulses in cycle 2+READ_CLOCK_CYCLES (cycle 4 at default).
- REGISTER_GPU_PORT=0: the GPU command is valid in cycle 1, and gpu_rd_rdy pulses in cycle 1+READ_CLOCK_CYCLES.
- gpu_rd_rdy is always exactly READ_CLOCK_CYCLES cycles after the GPU-port command cycle. Pulses for back-to-back reads land on consecutive cycles.
- fifo_full and overflow update on the edge that causes the change.

## Test plan
- **Single read.** Port 1 rd_req, address 0x12345, defaults.
  - The GPU port shows address 0x12345 with wr_ena=0 in cycle 2.
  - gpu_rd_rdy=4'b0010 in cycle 4.
  - data_out equals the modelled RAM data.
- **Round-robin.** All 4 ports strobe reads in the same cycle. Grants go to ports 0,1,2,3 in cycles 1–4, and gpu_rd_rdy is one-hot in cycles 4–7 in that order.
- **Fixed priority.** ARB_MODE=1, port 0 issues reads every cycle for 10 cycles and port 3 issues one read. Port 3 is granted only after port 0's FIFO drains.
- **Overflow.** FIFO_DEPTH=4; port 2 issues 6 writes while port 0 holds the bus.
  - fifo_full[2]=1 after the 4th write.
  - Writes 5 and 6 are dropped and overflow[2]=1 stays set.
  - Exactly 4 gpu_wr_ena pulses occur for port 2, with data 0x0000..0x0003.
- **Write + read collision.** Port 0 asserts wr_ena and rd_req together with ena_16bit=1 and data 0xBEEF. The GPU sees exactly one write (gpu_ena_16bit=1, gpu_data_out=0xBEEF) and no gpu_rd_rdy pulse.
- **Reset mid-operation.** Assert reset low one cycle after a read grant. All outputs go to 0 immediately, no gpu_rd_rdy pulse follows, and a read issued after release completes at normal latency.
